// File: rtl/snd_mix_ds.sv
// Serial N-channel audio mixer with master volume, clamp and a 1-bit delta-sigma DAC.
// Define DS_ORDER2_EN to build the 2nd-order modulator instead of the 1st-order one.
`timescale 1ns/1ps
module snd_mix_ds #(
    parameter int CH    = 4,
    parameter int VW    = 8,
    parameter int GW    = 8,
    parameter int DEPTH = 12
) (
    input  logic                clk,
    input  logic                map_rst_n,
    input  logic                smp_stb,
    input  logic [CH*VW-1:0]    ch_vol,
    input  logic [CH*GW-1:0]    ch_gain,
    input  logic [CH-1:0]       ch_mute,
    input  logic [7:0]          master_vol,
    output logic                busy,
    output logic [DEPTH-1:0]    mix_out,
    output logic                mix_vld,
    output logic                clip,
    output logic                ovr,
    output logic                snd
);
    localparam int LG    = (CH > 1) ? $clog2(CH) : 0;
    localparam int IW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int TW    = VW + GW;
    localparam int ACCW  = TW + LG;
    localparam int SHR   = 7 + ACCW - DEPTH;
    localparam int SHIFT = (SHR > 0) ? SHR : 0;
    localparam int PW    = ACCW + 8;
    localparam int MW    = (PW > DEPTH) ? PW : DEPTH + 1;

    typedef enum logic [1:0] {IDLE, ACC, SCALE, DONE} state_t;

    state_t             state, state_nx;
    logic               load, commit, last, pend, stb_q, over;
    logic [IW-1:0]      idx;
    logic [ACCW-1:0]    acc;
    logic [CH*VW-1:0]   vol_q;
    logic [CH*GW-1:0]   gain_q;
    logic [CH-1:0]      mute_q;
    logic [7:0]         master_q;
    logic [VW-1:0]      cur_vol;
    logic [GW-1:0]      cur_gain;
    logic [TW-1:0]      term;
    logic [MW-1:0]      prod, m_full;
    logic [DEPTH-1:0]   mval;

    assign cur_vol  = vol_q[idx*VW +: VW];
    assign cur_gain = gain_q[idx*GW +: GW];
    assign last     = (idx == IW'(CH - 1));

    always_comb begin
        term = '0;
        if (!mute_q[idx])
            term = TW'(cur_vol) * TW'(cur_gain);
    end

    always_comb begin
        prod   = MW'(acc) * MW'(master_q);
        m_full = prod >> SHIFT;
        over   = (m_full > MW'((1 << DEPTH) - 1));
        mval   = over ? '1 : m_full[DEPTH-1:0];
    end

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // A pending strobe chains straight from DONE into the next accumulation
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (smp_stb || pend) begin
                    load     = 1'b1;
                    state_nx = ACC;
                end
            end
            ACC: begin
                if (last)
                    state_nx = SCALE;
            end
            SCALE: begin
                commit   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                if (pend) begin
                    load     = 1'b1;
                    state_nx = ACC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state == ACC) || (state == SCALE);
    assign mix_vld = (state == DONE);
    assign stb_q   = smp_stb && !(state == IDLE && !pend);

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            vol_q    <= '0;
            gain_q   <= '0;
            mute_q   <= '0;
            master_q <= '0;
            acc      <= '0;
            idx      <= '0;
            mix_out  <= '0;
            clip     <= 1'b0;
            ovr      <= 1'b0;
            pend     <= 1'b0;
        end else begin
            if (load) begin
                vol_q    <= ch_vol;
                gain_q   <= ch_gain;
                mute_q   <= ch_mute;
                master_q <= master_vol;
                acc      <= '0;
                idx      <= '0;
            end else if (state == ACC) begin
                acc <= acc + ACCW'(term);
                idx <= idx + IW'(1);
            end
            if (commit) begin
                mix_out <= mval;
                if (over)
                    clip <= 1'b1;
            end
            if (load)
                pend <= stb_q;
            else if (stb_q) begin
                if (pend)
                    ovr <= 1'b1;
                else
                    pend <= 1'b1;
            end
        end
    end

`ifdef DS_ORDER2_EN
    localparam int DW = DEPTH + 4;

    logic signed [DW-1:0] i1, i2, fb, i1_nx, i2_nx;

    always_comb begin
        fb    = snd ? DW'(1 << DEPTH) : '0;
        i1_nx = i1 + $signed({4'b0, mix_out}) - fb;
        i2_nx = i2 + i1_nx - fb;
    end

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            i1  <= '0;
            i2  <= '0;
            snd <= 1'b0;
        end else begin
            i1  <= i1_nx;
            i2  <= i2_nx;
            snd <= !i2_nx[DW-1];
        end
    end
`else
    logic [DEPTH-1:0] dacc;
    logic [DEPTH:0]   dsum;

    assign dsum = {1'b0, dacc} + {1'b0, mix_out};

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            dacc <= '0;
            snd  <= 1'b0;
        end else begin
            dacc <= dsum[DEPTH-1:0];
            snd  <= dsum[DEPTH];
        end
    end
`endif
endmodule

// File: tb/tb_snd_mix_ds.sv
// Directed bench for snd_mix_ds: latency, clamp, strobe queueing, snapshot, reset, DSM density.
`timescale 1ns/1ps
module tb_snd_mix_ds;
    logic        clk;
    logic        map_rst_n;
    logic        smp_stb;
    logic [31:0] ch_vol;
    logic [31:0] ch_gain;
    logic [3:0]  ch_mute;
    logic [7:0]  master_vol;
    logic        busy;
    logic [11:0] mix_out;
    logic        mix_vld;
    logic        clip;
    logic        ovr;
    logic        snd;

    int checks = 0;
    int errors = 0;

    snd_mix_ds #(.CH(4), .VW(8), .GW(8), .DEPTH(12)) dut (
        .clk        (clk),
        .map_rst_n  (map_rst_n),
        .smp_stb    (smp_stb),
        .ch_vol     (ch_vol),
        .ch_gain    (ch_gain),
        .ch_mute    (ch_mute),
        .master_vol (master_vol),
        .busy       (busy),
        .mix_out    (mix_out),
        .mix_vld    (mix_vld),
        .clip       (clip),
        .ovr        (ovr),
        .snd        (snd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        map_rst_n = 1'b0;
        smp_stb   = 1'b0;
        tick();
        tick();
        map_rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg(input logic [31:0] v, input logic [31:0] g,
                       input logic [3:0] m, input logic [7:0] mst);
        ch_vol     = v;
        ch_gain    = g;
        ch_mute    = m;
        master_vol = mst;
    endtask

    // strobe in cycle 0; returns in the mix_vld cycle with its cycle number (-1 on timeout)
    task automatic run_mix(output int vc);
        smp_stb = 1'b1;
        tick();
        smp_stb = 1'b0;
        vc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (mix_vld) begin
                vc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, mix_vld, clip, ovr, snd} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {busy, mix_vld, clip, ovr, snd});
        end
        checks++;
        if (mix_out !== 12'd0) begin
            errors++;
            $display("FAIL reset_mix_out got %0d want 0", mix_out);
        end
    endtask

    task automatic test_single();
        logic [7:0] bv, vv;
        logic [11:0] m6;
        bv = '0;
        vv = '0;
        m6 = '0;
        cfg(32'h000000FF, 32'h000000FF, 4'b1110, 8'd128);
        smp_stb = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            smp_stb = 1'b0;
            bv[c] = busy;
            vv[c] = mix_vld;
            if (c == 6) m6 = mix_out;
        end
        checks++;
        if (bv !== 8'b0011_1110) begin
            errors++;
            $display("FAIL single_busy got %b want 00111110", bv);
        end
        checks++;
        if (vv !== 8'b0100_0000) begin
            errors++;
            $display("FAIL single_vld got %b want 01000000", vv);
        end
        checks++;
        if (m6 !== 12'd1016) begin
            errors++;
            $display("FAIL single_mix_out got %0d want 1016", m6);
        end
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL single_clip got %b want 0", clip);
        end
    endtask

    task automatic test_clip();
        int vc;
        do_reset();
        cfg(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 8'd255);
        run_mix(vc);
        checks++;
        if (vc !== 6 || mix_out !== 12'd4095) begin
            errors++;
            $display("FAIL clip_value got cyc %0d val %0d want cyc 6 val 4095", vc, mix_out);
        end
        checks++;
        if (clip !== 1'b1) begin
            errors++;
            $display("FAIL clip_flag got %b want 1", clip);
        end
        tick();
        cfg(32'h000000FF, 32'h000000FF, 4'b1110, 8'd128);
        run_mix(vc);
        checks++;
        if (mix_out !== 12'd1016 || clip !== 1'b1) begin
            errors++;
            $display("FAIL clip_sticky got val %0d clip %b want 1016 1", mix_out, clip);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bv, vv;
        bv = '0;
        vv = '0;
        do_reset();
        cfg(32'h000000FF, 32'h000000FF, 4'b1110, 8'd128);
        smp_stb = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            smp_stb = (c == 2) || (c == 3);
            bv[c] = busy;
            vv[c] = mix_vld;
        end
        checks++;
        if (vv !== 16'h1040) begin
            errors++;
            $display("FAIL b2b_vld got %h want 1040", vv);
        end
        checks++;
        if (bv !== 16'h0FBE) begin
            errors++;
            $display("FAIL b2b_busy got %h want 0fbe", bv);
        end
        checks++;
        if (ovr !== 1'b1 || mix_out !== 12'd1016) begin
            errors++;
            $display("FAIL b2b_ovr got ovr %b val %0d want 1 1016", ovr, mix_out);
        end
    endtask

    task automatic test_snapshot();
        int vc;
        vc = -1;
        do_reset();
        cfg(32'h000000FF, 32'h000000FF, 4'b1110, 8'd128);
        smp_stb = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            smp_stb = 1'b0;
            if (c == 2) cfg(32'h0, 32'h0, 4'b1111, 8'd0);
            if (mix_vld) begin
                vc = c;
                break;
            end
        end
        checks++;
        if (vc !== 6 || mix_out !== 12'd1016) begin
            errors++;
            $display("FAIL snapshot got cyc %0d val %0d want cyc 6 val 1016", vc, mix_out);
        end
    endtask

    task automatic test_async_reset();
        int vc;
        do_reset();
        cfg(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 8'd255);
        run_mix(vc);
        tick();
        smp_stb = 1'b1;
        tick();
        smp_stb = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || clip !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got busy %b clip %b want 1 1", busy, clip);
        end
        map_rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, mix_vld, clip, ovr, snd} !== 5'b0 || mix_out !== 12'd0) begin
            errors++;
            $display("FAIL arst_now got flags %b val %0d want 00000 0",
                     {busy, mix_vld, clip, ovr, snd}, mix_out);
        end
        tick();
        map_rst_n = 1'b1;
        tick();
        cfg(32'h000000FF, 32'h000000FF, 4'b1110, 8'd128);
        run_mix(vc);
        checks++;
        if (vc !== 6 || mix_out !== 12'd1016) begin
            errors++;
            $display("FAIL arst_after got cyc %0d val %0d want cyc 6 val 1016", vc, mix_out);
        end
    endtask

    task automatic test_dsm();
        int vc;
        int bad;
        int ones;
        logic prev;
        do_reset();
        cfg(32'h000023FF, 32'h000016FF, 4'b1100, 8'd255);
        run_mix(vc);
        checks++;
        if (mix_out !== 12'd2048) begin
            errors++;
            $display("FAIL dsm_half_val got %0d want 2048", mix_out);
        end
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            prev = snd;
            tick();
            if (snd === prev) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL dsm_alternate got %0d repeats want 0", bad);
        end
        cfg(32'h0, 32'h0, 4'b1111, 8'd128);
        run_mix(vc);
        tick();
        tick();
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (snd) ones++;
            tick();
        end
        checks++;
        if (mix_out !== 12'd0 || ones !== 0) begin
            errors++;
            $display("FAIL dsm_zero got val %0d ones %0d want 0 0", mix_out, ones);
        end
        cfg(32'h000007FF, 32'h000049FF, 4'b1100, 8'd128);
        run_mix(vc);
        checks++;
        if (mix_out !== 12'd1024) begin
            errors++;
            $display("FAIL dsm_quarter_val got %0d want 1024", mix_out);
        end
        tick();
        tick();
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            if (snd) ones++;
            tick();
        end
        checks++;
        if (ones !== 1024) begin
            errors++;
            $display("FAIL dsm_density got %0d ones want 1024", ones);
        end
    endtask

    initial begin
        map_rst_n = 1'b0;
        smp_stb   = 1'b0;
        cfg(32'h0, 32'h0, 4'b1111, 8'd0);
        test_reset();
        test_single();
        test_clip();
        test_back_to_back();
        test_snapshot();
        test_async_reset();
        test_dsm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
